// File: rtl/pic_param_ctrl.sv
// Programmable interrupt controller: synchronised IR inputs, IRR/ISR/IMR
// bookkeeping, rotating or fixed priority, and a two-state INTA handshake
// that places {BASE, level} on DataOut while acknowledge is held low.
//
// state | meaning
// IDLE  | waiting for INTA to fall; INT reflects pending unmasked requests
// ACK   | acknowledge in progress; vector {BASE, W} driven on DataOut
module pic_param_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             WR,
  input  logic             RD,
  input  logic             A0,
  input  logic [7:0]       DataIn,
  output logic [7:0]       DataOut,
  output logic             DataOE,
  input  logic [N_IRQ-1:0] IR,
  output logic             INT,
  input  logic             INTA
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] ir_s, ir_d, ir_rise;
  logic [N_IRQ-1:0] irr, isr, imr, req;
  logic [N_IRQ-1:0] irr_d, isr_d, isr_eoi;
  logic [4:0]       base;
  logic             ltim, rot, aeoi, rsel;
  logic [2:0]       lp, lp_d, lp_eoi;
  logic [2:0]       w_lvl;
  logic             w_valid;
  logic             wr_prev, inta_prev, int_q;
  logic             wr_pulse, ack_start, ack_end;
  logic [2:0]       cmd;
  logic [3:0]       nsp, rp, ip, qp, sp;
  logic             win_ok, int_ok;

  // Highest-priority set bit of vec: {found, level}. Rank 0 is level lp+1.
  function automatic logic [3:0] pick(input logic [N_IRQ-1:0] vec,
                                      input logic [2:0] lp_v);
    logic [3:0]    r;
    logic [IW-1:0] l;
    int            lw;
    r = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      lw = int'(lp_v) + 1 + i;
      l  = (lw >= N_IRQ) ? IW'(lw - N_IRQ) : IW'(lw);
      if (vec[l]) r = {1'b1, 3'(l)};
    end
    return r;
  endfunction

  // Priority rank of a level relative to lp (0 = highest).
  function automatic logic [2:0] rank_of(input logic [2:0] lvl,
                                         input logic [2:0] lp_v);
    int r;
    r = int'(lvl) - int'(lp_v) - 1;
    if (r < 0) r = r + N_IRQ;
    return 3'(r);
  endfunction

  assign ir_s     = sync_q[SYNC_STAGES-1];
  assign ir_rise  = ir_s & ~ir_d;
  assign wr_pulse = ~CS & ~WR & wr_prev;
  assign cmd      = DataIn[7:5];
  assign req      = irr & ~imr;
  assign INT      = int_q;

  // EOI commands take effect before any acknowledge in the same cycle.
  always_comb begin
    isr_eoi = isr;
    lp_eoi  = lp;
    nsp     = pick(isr, lp);
    if (wr_pulse && !A0) begin
      if (cmd == 3'b001 && nsp[3]) begin
        isr_eoi[nsp[IW-1:0]] = 1'b0;
        if (rot) lp_eoi = nsp[2:0];
      end else if (cmd == 3'b011 && int'(DataIn[2:0]) < N_IRQ) begin
        isr_eoi[DataIn[IW-1:0]] = 1'b0;
      end
    end
  end

  // Winner for a starting acknowledge, and the fully nested INT condition.
  always_comb begin
    rp     = pick(req, lp_eoi);
    ip     = pick(isr_eoi, lp_eoi);
    win_ok = rp[3] && (!ip[3] || (rank_of(rp[2:0], lp_eoi) < rank_of(ip[2:0], lp_eoi)));
    qp     = pick(req, lp);
    sp     = pick(isr, lp);
    int_ok = qp[3] && (!sp[3] || (rank_of(qp[2:0], lp) < rank_of(sp[2:0], lp)));
  end

  // Acknowledge handshake next-state decode.
  always_comb begin
    state_d   = state_q;
    ack_start = 1'b0;
    ack_end   = 1'b0;
    case (state_q)
      IDLE: if (!INTA && inta_prev) begin
        state_d   = ACK;
        ack_start = 1'b1;
      end
      ACK: if (INTA) begin
        state_d = IDLE;
        ack_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next IRR/ISR/LP; a fresh edge on the acknowledged level keeps IRR set.
  always_comb begin
    irr_d = ltim ? ir_s : (irr | ir_rise);
    isr_d = isr_eoi;
    lp_d  = lp_eoi;
    if (ack_start && win_ok) begin
      isr_d[rp[IW-1:0]] = 1'b1;
      if (!ir_rise[rp[IW-1:0]]) irr_d[rp[IW-1:0]] = 1'b0;
    end
    if (ack_end && aeoi && w_valid) begin
      isr_d[w_lvl[IW-1:0]] = 1'b0;
      if (rot) lp_d = w_lvl;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Synchronisers, request/service registers, configuration and INT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      ir_d      <= '0;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      base      <= '0;
      ltim      <= 1'b0;
      rot       <= 1'b0;
      aeoi      <= 1'b0;
      rsel      <= 1'b0;
      lp        <= 3'(N_IRQ - 1);
      w_lvl     <= '0;
      w_valid   <= 1'b0;
      wr_prev   <= 1'b0;
      inta_prev <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      sync_q[0] <= IR;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      ir_d      <= ir_s;
      irr       <= irr_d;
      isr       <= isr_d;
      lp        <= lp_d;
      wr_prev   <= WR;
      inta_prev <= INTA;
      int_q     <= ack_start ? 1'b0 : int_ok;
      if (wr_pulse) begin
        if (A0) begin
          imr <= DataIn[N_IRQ-1:0];
        end else begin
          case (cmd)
            3'b010:  rsel <= DataIn[0];
            3'b100:  base <= DataIn[4:0];
            3'b101:  ltim <= DataIn[0];
            3'b110:  rot  <= DataIn[0];
            3'b111:  aeoi <= DataIn[0];
            default: ;
          endcase
        end
      end
      if (ack_start) begin
        w_lvl   <= win_ok ? rp[2:0] : 3'(N_IRQ - 1);
        w_valid <= win_ok;
      end
    end
  end

  // Data bus: acknowledge vector has precedence over a register read.
  always_comb begin
    DataOE  = 1'b0;
    DataOut = '0;
    if (rst_n) begin
      if (state_q == ACK) begin
        DataOE  = 1'b1;
        DataOut = {base, w_lvl};
      end else if (!CS && !RD && INTA) begin
        DataOE  = 1'b1;
        DataOut = A0 ? 8'(imr) : (rsel ? 8'(isr) : 8'(irr));
      end
    end
  end

endmodule

// File: doc/pic_param_ctrl.md
PIC_PARAM_CTRL -- requirements
Module: pic_param_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of interrupt inputs (legal 2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on IR inputs (legal 2..3).
REQ-003 SHALL have ports, in order: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have: rst_n  input  1  synchronous active-low reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have: CS  input  1  chip select, active-low.
REQ-006 SHALL have: WR  input  1  write strobe, active-low.
REQ-007 SHALL have: RD  input  1  read strobe, active-low.
REQ-008 SHALL have: A0  input  1  register select.
REQ-009 SHALL have: DataIn  input  8  write data.
REQ-010 SHALL have: DataOut  output  8  read data / interrupt vector.
REQ-011 SHALL have: DataOE  output  1  DataOut valid, drives external tristate.
REQ-012 SHALL have: IR  input  N_IRQ  asynchronous interrupt requests, IR[0] = level 0.
REQ-013 SHALL have: INT  output  1  registered interrupt request to CPU, active-high.
REQ-014 SHALL have: INTA  input  1  interrupt acknowledge, active-low.

Function
REQ-015 SHALL pass each IR bit through SYNC_STAGES flops before use.
REQ-016 SHALL accept a write once per WR low pulse: on the first clk where CS=0, WR=0 and WR was 1 the previous cycle.
REQ-017 SHALL on A0=1 write load IMR <= DataIn[N_IRQ-1:0]; IMR bit 1 masks that level.
REQ-018 SHALL on A0=0 write decode DataIn[7:5]: 000 nop; 001 non-specific EOI; 010 read-select RSEL<=DataIn[0] (0 IRR, 1 ISR); 011 specific EOI level DataIn[2:0]; 100 BASE<=DataIn[4:0]; 101 LTIM<=DataIn[0] (1 level, 0 edge); 110 ROT<=DataIn[0]; 111 AEOI<=DataIn[0].
REQ-019 SHALL, when CS=0, RD=0, INTA=1, drive DataOE=1 and DataOut = A0 ? IMR : (RSEL ? ISR : IRR), zero-extended, combinationally.
REQ-020 SHALL in edge mode set IRR[k] on synchronised 0->1 of IR[k]; in level mode IRR[k] follows synchronised IR[k]; IRR[k] also clears on acknowledge.
REQ-021 SHALL rank priority from level (LP+1) mod N_IRQ highest to LP lowest; LP resets to N_IRQ-1 (level 0 highest).
REQ-022 SHALL assert INT (registered, one-cycle latency) when some IRR & ~IMR bit outranks every set ISR bit (fully nested); INT=0 otherwise.
REQ-023 SHALL run FSM IDLE->ACK on first clk with INTA=0 after INTA=1; ACK->IDLE on first clk with INTA=1.
REQ-024 SHALL on IDLE->ACK latch winner W (highest-priority unmasked IRR bit outranking ISR), set ISR[W], clear IRR[W], deassert INT same edge.
REQ-025 SHALL in ACK drive DataOE=1, DataOut={BASE, W[2:0]}.
REQ-026 SHALL on spurious acknowledge (no qualifying request) return {BASE, N_IRQ-1 as 3 bits}, modify no ISR/IRR bit.
REQ-027 SHALL on ACK->IDLE with AEOI=1 clear ISR[W]; if ROT=1 also set LP<=W.
REQ-028 SHALL on non-specific EOI clear the highest-priority set ISR bit; if ROT=1 set LP to that level; no-op if ISR=0.
REQ-029 SHALL on specific EOI clear ISR[DataIn[2:0]] only, ignore levels >= N_IRQ, never change LP.
REQ-030 SHALL resolve same-cycle events: EOI clear applied before acknowledge set; new IR edge setting IRR[k] wins over acknowledge clearing IRR[k]; INTA read overrides RD read on DataOut.
REQ-031 SHALL ignore WR/RD while CS=1; IMR change takes effect on INT next cycle.

Reset
REQ-032 SHALL on clk edge with rst_n=0 set IRR=0, ISR=0, IMR=0, BASE=0, LTIM=0, ROT=0, AEOI=0, RSEL=0, LP=N_IRQ-1, FSM=IDLE, INT=0, DataOE=0, DataOut=0, synchronisers=0, edge-detect history=0.
REQ-033 SHALL on reset asserted mid-ACK abandon the acknowledge, return FSM to IDLE, and keep outputs at reset values while rst_n=0.

Verification
REQ-034 Bench SHALL check: BASE=5'h08, IR[3] rising, INTA pulse -> INT=1 within SYNC_STAGES+2 cycles, DataOut=8'h43 in ACK, ISR=8'h08, IRR=0.
REQ-035 Bench SHALL check: IR[5] and IR[2] same cycle, fixed priority -> vector level 2 first; non-specific EOI; second INTA -> level 5.
REQ-036 Bench SHALL check: ROT=1, IR[0] serviced + non-specific EOI -> LP=0; IR[0] and IR[1] simultaneous -> level 1 wins.
REQ-037 Bench SHALL check: IMR=8'h10, IR[4] pulse -> INT stays 0; IMR=0 write -> INT=1 next cycle+1 (edge latched in IRR).
REQ-038 Bench SHALL check: no IRQ pending, INTA pulse -> DataOut={BASE,3'd7}, ISR unchanged; AEOI=1 acknowledge of IR[6] -> ISR=0 after INTA rises.
REQ-039 Bench SHALL check: rst_n=0 during ACK -> next cycle DataOE=0, INT=0, ISR=0, IMR=0.
